fixed_mac_accum: RTL and testbench
==================================

Name: fixed_mac_accum

Overview:
- Pipelined fixed-point multiply-accumulate for svreal-style signals. Each signal is a signed integer mantissa with a fixed binary exponent.
- Multiplies two real-valued streams and accumulates N_ACC valid products. Emits one aligned sum per block, with optional saturation and a sticky overflow flag.
- Sits after synthesizable real-number datapaths (filters, integrators in emulated analog models) to decimate or integrate sample streams.

Parameters:
- A_WIDTH, 16, mantissa width of input a
- A_EXP, -8, exponent of a (value = a * 2^A_EXP)
- B_WIDTH, 17, mantissa width of input b
- B_EXP, -9, exponent of b
- ACC_WIDTH, 32, accumulator/output mantissa width
- ACC_EXP, -16, exponent of accumulator/output
- MUL_STAGES, 2, product pipeline registers (legal 1..3)
- N_ACC, 4, valid products per output (legal 1..65535)
- SATURATE, 1, 1 = clamp on overflow, 0 = two's-complement wrap

Ports:
- clk, in, 1, clock
- rst, in, 1, synchronous active-high reset
- cke, in, 1, clock enable; all registers hold when low
- clear, in, 1, synchronous flush of pipeline, counter, accumulator, ovf
- a, in, A_WIDTH signed, multiplicand mantissa
- b, in, B_WIDTH signed, multiplier mantissa
- in_valid, in, 1, a/b valid this cycle
- acc_o, out, ACC_WIDTH signed, accumulated sum (exponent ACC_EXP)
- out_valid, out, 1, one-cycle pulse: acc_o holds a completed sum
- ovf, out, 1, sticky overflow/saturation indicator

Behaviour:
- Interface clocking: one clock (clk); reset rst is synchronous and active-high.
- Reset values (rst=1 at posedge): acc_o=0, out_valid=0, ovf=0, internal accumulator=0, sample count=0, all pipeline valid bits=0.
- rst has priority over clear; clear has priority over cke gating. clear acts even when cke=0, with the same effect as rst.
- Product formation:
  - p = a*b, full precision, width A_WIDTH+B_WIDTH, exponent PE = A_EXP+B_EXP.
  - Alignment to ACC_EXP uses sh = ACC_EXP-PE.
  - sh > 0: arithmetic right shift by sh, truncating toward -inf.
  - sh < 0: left shift by -sh, sign-extended to ACC_WIDTH+2 guard bits.
  - Alignment is done in the final product stage.
- Pipeline: MUL_STAGES registers carry the aligned product and its valid bit. No backpressure; a new input is accepted every cycle that cke=1.
- Accumulate stage, one register stage, count-based FSM:
  - ACCUM (count < N_ACC-1): a valid product sets acc += p and count += 1. An invalid cycle (bubble) changes nothing.
  - DUMP (valid product with count == N_ACC-1):
    - acc_o <= sat(acc+p) and out_valid <= 1.
    - The internal acc restarts at 0 and count at 0. The next valid product starts a fresh sum, with no lost cycle.
  - out_valid <= 0 on every other enabled cycle.
- Latency: the valid sample completing a block, presented at edge t, produces out_valid=1 after edge t+MUL_STAGES+1.
- Overflow and saturation:
  - Each addition is computed with 1 guard bit.
  - If the result is outside [-2^(ACC_WIDTH-1), 2^(ACC_WIDTH-1)-1]:
    - SATURATE=1: clamp to the bound.
    - SATURATE=0: wrap.
  - ovf <= 1 in either mode. The internal acc continues from the clamped or wrapped value.
  - ovf clears only on rst or clear.
- acc_o holds its last dumped value until the next dump, rst or clear.
- N_ACC=1: every valid product is dumped directly, with acc_o = sat(p).
- cke=0: all registers (including out_valid and count) hold, and inputs are ignored. Downstream qualifies out_valid with cke.
- rst or clear mid-block: the partial sum and in-flight products are discarded. No out_valid is produced for the interrupted block.

Test Plan:
- Defaults. a=384 (1.5), b=1024 (2.0), in_valid=1 for 4 cycles -> one out_valid pulse 3 cycles after the 4th input, acc_o=786432 (12.0), ovf=0. A further 4 inputs -> second pulse, same value.
- Truncation, N_ACC=1. a=1, b=1 -> acc_o=0. a=-1, b=1 -> acc_o=-1 (floor, not toward zero).
- Saturation, N_ACC=8, SATURATE=1. a=32767, b=65535 repeatedly -> partial sums 1073692672, 2147385344, then clamp at 2147483647. Dump acc_o=2147483647, ovf=1. Repeat with a=-32768 -> acc_o=-2147483648, ovf stays 1.
- Bubbles and cke. Valid pattern 1,0,1,0,0,1,1 with a=384, b=1024 -> single dump of 786432 three cycles after the last valid. Dropping cke for 5 cycles mid-pipeline delays the pulse by exactly 5 cycles with the same value.
- Clear and reset mid-block. After 2 valid samples, assert clear for 1 cycle, then send 4 valid samples -> exactly one dump of 786432 and ovf=0. Assert rst with out_valid high -> the next cycle shows out_valid=0, acc_o=0.
- Wrap mode, SATURATE=0, same stimulus as the saturation scenario -> acc_o equals the 32-bit two's-complement wrapped sum and ovf=1.

Source files
------------

// File: rtl/fixed_mac_accum_if.sv
// fixed_mac_accum_if: sample bus into the MAC (a, b, in_valid) and sum bus out of it (acc_o, out_valid, ovf)
// Latency: none, wires only
// Backpressure: none; the producer may present a sample every enabled cycle
interface fixed_mac_accum_if #(
   parameter int A_WIDTH   = 16,
   parameter int B_WIDTH   = 17,
   parameter int ACC_WIDTH = 32
) ();

   logic signed [A_WIDTH-1:0]   a;
   logic signed [B_WIDTH-1:0]   b;
   logic                        in_valid;
   logic signed [ACC_WIDTH-1:0] acc_o;
   logic                        out_valid;
   logic                        ovf;

   // sample source / sum consumer side
   modport master (
      output a,
      output b,
      output in_valid,
      input  acc_o,
      input  out_valid,
      input  ovf
   );

   // MAC side
   modport slave (
      input  a,
      input  b,
      input  in_valid,
      output acc_o,
      output out_valid,
      output ovf
   );

endinterface

// File: rtl/fixed_mac_accum.sv
// fixed_mac_accum: fixed-point a*b multiply-accumulate, one aligned (optionally saturated) sum per N_ACC valid products
// Latency: valid sample taken at edge t -> out_valid pulse after edge t+MUL_STAGES+1
// Backpressure: none; a sample is accepted every cke=1 cycle, cke=0 freezes every register
module fixed_mac_accum #(
   parameter int A_WIDTH    = 16,
   parameter int A_EXP      = -8,
   parameter int B_WIDTH    = 17,
   parameter int B_EXP      = -9,
   parameter int ACC_WIDTH  = 32,
   parameter int ACC_EXP    = -16,
   parameter int MUL_STAGES = 2,
   parameter int N_ACC      = 4,
   parameter int SATURATE   = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cke,
   input  logic             clear,
   fixed_mac_accum_if.slave mac
);

   // full-precision product width and exponent shift needed to land on ACC_EXP
   localparam int PW = A_WIDTH + B_WIDTH;
   localparam int SH = ACC_EXP - (A_EXP + B_EXP);
   // aligned product keeps two guard bits above the accumulator width
   localparam int AW = ACC_WIDTH + 2;
   // extension width wide enough that either shift direction loses nothing before truncation to AW
   localparam int EW = PW + AW;
   // sum width: accumulator plus aligned product can never overflow this
   localparam int SW = ACC_WIDTH + 3;
   localparam int CW = (N_ACC > 1) ? $clog2(N_ACC) : 1;

   // count value whose next valid product arms the dump state
   localparam logic [CW-1:0] CNT_PRELAST = CW'((N_ACC > 1) ? (N_ACC - 2) : 0);

   // accumulator range bounds, sign-extended to the sum width
   localparam logic signed [SW-1:0] MAX_V = {{(SW-ACC_WIDTH+1){1'b0}}, {(ACC_WIDTH-1){1'b1}}};
   localparam logic signed [SW-1:0] MIN_V = {{(SW-ACC_WIDTH+1){1'b1}}, {(ACC_WIDTH-1){1'b0}}};

   // ST_LAST means the next valid product completes the block
   typedef enum logic {
      ST_FILL = 1'b0,
      ST_LAST = 1'b1
   } state_t;

   // ------------------------------------------------------------------
   // input capture
   // ------------------------------------------------------------------
   logic signed [A_WIDTH-1:0] r_a;
   logic signed [B_WIDTH-1:0] r_b;
   logic                      r_in_vld;

   // register the incoming sample so the multiplier sees clean flop outputs
   always_ff @(posedge clk) begin
      if (rst || clear) begin
         r_a      <= '0;
         r_b      <= '0;
         r_in_vld <= 1'b0;
      end else if (cke) begin
         r_a      <= mac.a;
         r_b      <= mac.b;
         r_in_vld <= mac.in_valid;
      end
   end

   // ------------------------------------------------------------------
   // product pipeline
   // ------------------------------------------------------------------
   logic signed [PW-1:0] w_prod;
   logic signed [PW-1:0] w_fin_raw;
   logic signed [EW-1:0] w_ext;
   logic signed [AW-1:0] w_aln;

   assign w_prod = PW'(r_a) * PW'(r_b);

   generate
      if (MUL_STAGES == 1) begin : g_raw_none
         assign w_fin_raw = w_prod;
      end else begin : g_raw_pipe
         logic signed [PW-1:0] r_raw [MUL_STAGES-1];

         // unaligned product delay stages ahead of the aligning stage
         always_ff @(posedge clk) begin
            if (rst || clear) begin
               for (int i = 0; i < MUL_STAGES - 1; i++) begin
                  r_raw[i] <= '0;
               end
            end else if (cke) begin
               r_raw[0] <= w_prod;
               for (int i = 1; i < MUL_STAGES - 1; i++) begin
                  r_raw[i] <= r_raw[i-1];
               end
            end
         end

         assign w_fin_raw = r_raw[MUL_STAGES-2];
      end
   endgenerate

   // sign-extend before shifting so a right shift floors and a left shift keeps its sign
   assign w_ext = EW'(w_fin_raw);

   generate
      if (SH >= 0) begin : g_shr
         assign w_aln = AW'(w_ext >>> SH);
      end else begin : g_shl
         assign w_aln = AW'(w_ext <<< (-SH));
      end
   endgenerate

   logic [MUL_STAGES-1:0] r_pv;
   logic signed [AW-1:0]  r_pfin;

   // final product stage: aligned product plus the valid bits walking alongside the data
   always_ff @(posedge clk) begin
      if (rst || clear) begin
         r_pv   <= '0;
         r_pfin <= '0;
      end else if (cke) begin
         r_pv[0] <= r_in_vld;
         for (int i = 1; i < MUL_STAGES; i++) begin
            r_pv[i] <= r_pv[i-1];
         end
         r_pfin <= w_aln;
      end
   end

   // ------------------------------------------------------------------
   // accumulate / dump
   // ------------------------------------------------------------------
   logic signed [ACC_WIDTH-1:0] r_acc;
   logic [CW-1:0]               r_cnt;
   state_t                      r_state;
   logic signed [ACC_WIDTH-1:0] r_acc_o;
   logic                        r_out_valid;
   logic                        r_ovf;

   logic signed [SW-1:0]        w_sum;
   logic                        w_hi;
   logic                        w_lo;
   logic signed [ACC_WIDTH-1:0] w_res;

   // exact sum, range test, then clamp or wrap back to the accumulator width
   always_comb begin
      w_sum = SW'(r_acc) + SW'(r_pfin);
      w_hi  = (w_sum > MAX_V);
      w_lo  = (w_sum < MIN_V);
      w_res = w_sum[ACC_WIDTH-1:0];
      if (SATURATE != 0) begin
         if (w_hi) begin
            w_res = MAX_V[ACC_WIDTH-1:0];
         end else if (w_lo) begin
            w_res = MIN_V[ACC_WIDTH-1:0];
         end
      end
   end

   // count-driven accumulate FSM; the product that completes a block goes straight to acc_o
   always_ff @(posedge clk) begin
      if (rst || clear) begin
         r_acc       <= '0;
         r_cnt       <= '0;
         r_state     <= (N_ACC == 1) ? ST_LAST : ST_FILL;
         r_acc_o     <= '0;
         r_out_valid <= 1'b0;
         r_ovf       <= 1'b0;
      end else if (cke) begin
         r_out_valid <= 1'b0;
         if (r_pv[MUL_STAGES-1]) begin
            if (w_hi || w_lo) begin
               r_ovf <= 1'b1;
            end
            if (r_state == ST_LAST) begin
               r_acc_o     <= w_res;
               r_out_valid <= 1'b1;
               r_acc       <= '0;
               r_cnt       <= '0;
               r_state     <= (N_ACC == 1) ? ST_LAST : ST_FILL;
            end else begin
               r_acc   <= w_res;
               r_cnt   <= r_cnt + CW'(1);
               r_state <= (r_cnt == CNT_PRELAST) ? ST_LAST : ST_FILL;
            end
         end
      end
   end

   assign mac.acc_o     = r_acc_o;
   assign mac.out_valid = r_out_valid;
   assign mac.ovf       = r_ovf;

endmodule

// File: tb/tb_fixed_mac_accum.sv
// tb_fixed_mac_accum: four MAC configurations driven by one shared stimulus stream, scoreboard-checked
// Latency: model releases each sample after MUL_STAGES+1 enabled edges
// Backpressure: none; cke and clear are exercised directly
`timescale 1ns/1ps
module tb_fixed_mac_accum;

   localparam int ND = 4;
   localparam int MULS [ND] = '{2, 1, 3, 2};
   localparam int NACC [ND] = '{4, 1, 8, 8};
   localparam int SATM [ND] = '{1, 1, 1, 0};
   // product exponent -17, accumulator exponent -16
   localparam int SHIFT = -16 - (-8 + -9);
   localparam longint MAXV = 64'sd2147483647;
   localparam longint MINV = -64'sd2147483648;

   typedef struct packed {
      logic        v;
      logic [15:0] a;
      logic [16:0] b;
   } smp_t;

   typedef struct packed {
      logic [31:0] val;
      logic        ovf;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic               rst;
   logic               cke;
   logic               clear;
   logic               in_valid;
   logic signed [15:0] a;
   logic signed [16:0] b;
   logic               done;

   int checks   = 0;
   int failures = 0;

   fixed_mac_accum_if #(.A_WIDTH(16), .B_WIDTH(17), .ACC_WIDTH(32)) if0 ();
   fixed_mac_accum_if #(.A_WIDTH(16), .B_WIDTH(17), .ACC_WIDTH(32)) if1 ();
   fixed_mac_accum_if #(.A_WIDTH(16), .B_WIDTH(17), .ACC_WIDTH(32)) if2 ();
   fixed_mac_accum_if #(.A_WIDTH(16), .B_WIDTH(17), .ACC_WIDTH(32)) if3 ();

   assign if0.a = a;  assign if0.b = b;  assign if0.in_valid = in_valid;
   assign if1.a = a;  assign if1.b = b;  assign if1.in_valid = in_valid;
   assign if2.a = a;  assign if2.b = b;  assign if2.in_valid = in_valid;
   assign if3.a = a;  assign if3.b = b;  assign if3.in_valid = in_valid;

   logic signed [31:0] dut_acc [ND];
   logic               dut_vld [ND];
   logic               dut_ovf [ND];

   assign dut_acc[0] = if0.acc_o;  assign dut_vld[0] = if0.out_valid;  assign dut_ovf[0] = if0.ovf;
   assign dut_acc[1] = if1.acc_o;  assign dut_vld[1] = if1.out_valid;  assign dut_ovf[1] = if1.ovf;
   assign dut_acc[2] = if2.acc_o;  assign dut_vld[2] = if2.out_valid;  assign dut_ovf[2] = if2.ovf;
   assign dut_acc[3] = if3.acc_o;  assign dut_vld[3] = if3.out_valid;  assign dut_ovf[3] = if3.ovf;

   fixed_mac_accum #(.MUL_STAGES(2), .N_ACC(4), .SATURATE(1)) u_dut0 (
      .clk(clk), .rst(rst), .cke(cke), .clear(clear), .mac(if0.slave));
   fixed_mac_accum #(.MUL_STAGES(1), .N_ACC(1), .SATURATE(1)) u_dut1 (
      .clk(clk), .rst(rst), .cke(cke), .clear(clear), .mac(if1.slave));
   fixed_mac_accum #(.MUL_STAGES(3), .N_ACC(8), .SATURATE(1)) u_dut2 (
      .clk(clk), .rst(rst), .cke(cke), .clear(clear), .mac(if2.slave));
   fixed_mac_accum #(.MUL_STAGES(2), .N_ACC(8), .SATURATE(0)) u_dut3 (
      .clk(clk), .rst(rst), .cke(cke), .clear(clear), .mac(if3.slave));

   // reference model state
   smp_t        dl [ND][$];
   exp_t        sb [ND][$];
   longint      m_sum  [ND] = '{default: 0};
   int          m_cnt  [ND] = '{default: 0};
   logic        m_ovf  [ND] = '{default: 1'b0};
   logic [31:0] m_acco [ND] = '{default: 32'd0};

   // reference model: each enabled edge takes one sample in; a sample is accumulated
   // once it has been in flight for MUL_STAGES+1 enabled edges
   initial begin : model
      smp_t   s;
      longint p;
      longint s2;
      forever begin
         @(posedge clk);
         for (int d = 0; d < ND; d++) begin
            if (rst || clear) begin
               dl[d].delete();
               sb[d].delete();
               m_sum[d]  = 0;
               m_cnt[d]  = 0;
               m_ovf[d]  = 1'b0;
               m_acco[d] = 32'd0;
            end else if (cke) begin
               if (dl[d].size() == MULS[d] + 1) begin
                  s = dl[d].pop_front();
                  if (s.v) begin
                     // arithmetic shift of a signed 64-bit value floors toward -inf
                     p  = (longint'($signed(s.a)) * longint'($signed(s.b))) >>> SHIFT;
                     s2 = m_sum[d] + p;
                     if (s2 > MAXV || s2 < MINV) begin
                        m_ovf[d] = 1'b1;
                        if (SATM[d] != 0) s2 = (s2 > MAXV) ? MAXV : MINV;
                        else              s2 = longint'(int'(s2));
                     end
                     m_cnt[d]++;
                     if (m_cnt[d] == NACC[d]) begin
                        m_acco[d] = s2[31:0];
                        sb[d].push_back({s2[31:0], m_ovf[d]});
                        m_sum[d] = 0;
                        m_cnt[d] = 0;
                     end else begin
                        m_sum[d] = s2;
                     end
                  end
               end
               dl[d].push_back({in_valid, a, b});
            end
         end
      end
   end

   // monitor: consumes outputs 1 ns after each edge and compares against the scoreboard
   initial begin : monitor
      bit   e_rst;
      bit   e_clr;
      bit   e_cke;
      bit   want;
      exp_t e;
      forever begin
         @(posedge clk);
         e_rst = rst;
         e_clr = clear;
         e_cke = cke;
         #1;
         for (int d = 0; d < ND; d++) begin
            if (e_rst || e_clr) begin
               checks++;
               if (dut_vld[d] !== 1'b0 || dut_acc[d] !== 32'sd0 || dut_ovf[d] !== 1'b0) begin
                  failures++;
                  $display("FAIL flush dut%0d t=%0t: out_valid=%0b acc_o=%0d ovf=%0b, required 0/0/0",
                           d, $time, dut_vld[d], dut_acc[d], dut_ovf[d]);
               end
            end else if (e_cke) begin
               want = (sb[d].size() > 0);
               checks++;
               if (dut_vld[d] !== want) begin
                  failures++;
                  $display("FAIL pulse dut%0d t=%0t: out_valid=%0b required %0b", d, $time, dut_vld[d], want);
               end
               if (want) begin
                  e = sb[d].pop_front();
                  if (dut_vld[d] === 1'b1) begin
                     checks++;
                     if (dut_acc[d] !== $signed(e.val) || dut_ovf[d] !== e.ovf) begin
                        failures++;
                        $display("FAIL dump dut%0d t=%0t: acc_o=%0d ovf=%0b required acc_o=%0d ovf=%0b",
                                 d, $time, dut_acc[d], dut_ovf[d], $signed(e.val), e.ovf);
                     end
                  end
               end
            end
            checks++;
            if (dut_acc[d] !== $signed(m_acco[d]) || dut_ovf[d] !== m_ovf[d]) begin
               failures++;
               $display("FAIL hold dut%0d t=%0t: acc_o=%0d ovf=%0b required acc_o=%0d ovf=%0b",
                        d, $time, dut_acc[d], dut_ovf[d], $signed(m_acco[d]), m_ovf[d]);
            end
         end
         if (done) begin
            $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
            $finish;
         end
      end
   end

   task automatic step(input logic v, input int av, input int bv);
      in_valid = v;
      a        = 16'(av);
      b        = 17'(bv);
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 0, 0);
   endtask

   task automatic pulse_clear();
      clear = 1'b1;
      step(1'b0, 0, 0);
      clear = 1'b0;
   endtask

   // stimulus: directed scenarios first, then a randomized soak
   initial begin : stim
      bit pat [7] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
      rst = 1'b1; cke = 1'b1; clear = 1'b0; in_valid = 1'b0; a = '0; b = '0; done = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;

      // 1.5 * 2.0 blocks
      repeat (4) step(1'b1, 384, 1024);
      idle(6);
      repeat (4) step(1'b1, 384, 1024);
      idle(6);
      pulse_clear();

      // floor truncation on the single-product configuration
      step(1'b1, 1, 1);
      step(1'b1, -1, 1);
      idle(6);
      pulse_clear();

      // positive then negative saturation; ovf stays set across blocks
      repeat (8) step(1'b1, 32767, 65535);
      idle(6);
      repeat (8) step(1'b1, -32768, 65535);
      idle(6);
      pulse_clear();

      // bubbles between valid samples
      for (int i = 0; i < 7; i++) step(pat[i], 384, 1024);
      idle(6);
      pulse_clear();

      // cke dropped for 5 cycles with junk presented on the inputs
      repeat (4) step(1'b1, 384, 1024);
      cke = 1'b0;
      repeat (5) step(1'b1, 1000, 1000);
      cke = 1'b1;
      idle(8);

      // clear mid-block, then a clean block
      repeat (2) step(1'b1, 384, 1024);
      pulse_clear();
      repeat (4) step(1'b1, 384, 1024);
      idle(6);

      // set ovf, then clear while cke is low
      repeat (3) step(1'b1, 32767, 65535);
      idle(5);
      cke = 1'b0;
      pulse_clear();
      cke = 1'b1;
      idle(2);

      // reset landing on the edge after a dump pulse
      repeat (4) step(1'b1, 384, 1024);
      idle(3);
      rst = 1'b1;
      step(1'b0, 0, 0);
      rst = 1'b0;
      idle(2);

      // randomized soak
      for (int i = 0; i < 500; i++) begin
         cke   = ($urandom_range(0, 9) != 0);
         clear = ($urandom_range(0, 59) == 0);
         rst   = ($urandom_range(0, 149) == 0);
         step($urandom_range(0, 3) != 0, int'($urandom), int'($urandom));
      end
      cke = 1'b1; clear = 1'b0; rst = 1'b0;
      idle(12);
      done = 1'b1;
      idle(4);
   end

endmodule
